// File: rtl/copier_mc_if.sv
// Single-port memory bus shared by all copier_mc channels.
// The copier is the master; the memory answers with mem_ready/mem_rdata.
interface copier_mc_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/copier_mc.sv
// Multi-channel memory copier/filler with one shared memory port and word-level
// round-robin arbitration; copies run descending when dst > src so overlaps are safe.
module copier_mc #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NCH-1:0]        start,
  input  logic [NCH-1:0]        fill,
  input  logic [NCH*ADDR_W-1:0] src_addr,
  input  logic [NCH*ADDR_W-1:0] dst_addr,
  input  logic [NCH*LEN_W-1:0]  copy_size,
  input  logic [NCH*DATA_W-1:0] fill_data,
  output logic [NCH-1:0]        busy,
  output logic [NCH-1:0]        finished,
  copier_mc_if.master           mem
);
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            r_state;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_grant;
  logic [NCH-1:0]    r_busy;
  logic [NCH-1:0]    r_fin;
  logic [NCH-1:0]    r_fill;
  logic [NCH-1:0]    r_desc;
  logic [ADDR_W-1:0] r_rptr  [NCH];
  logic [ADDR_W-1:0] r_wptr  [NCH];
  logic [LEN_W-1:0]  r_rem   [NCH];
  logic [DATA_W-1:0] r_fdata [NCH];
  logic [DATA_W-1:0] r_buf;
  logic              r_ren;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [ADDR_W-1:0] w_src  [NCH];
  logic [ADDR_W-1:0] w_dst  [NCH];
  logic [LEN_W-1:0]  w_size [NCH];
  logic [DATA_W-1:0] w_fdat [NCH];
  logic              w_any;
  logic [IDX_W-1:0]  w_gnt;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_src[i]  = src_addr[i*ADDR_W +: ADDR_W];
      w_dst[i]  = dst_addr[i*ADDR_W +: ADDR_W];
      w_size[i] = copy_size[i*LEN_W +: LEN_W];
      w_fdat[i] = fill_data[i*DATA_W +: DATA_W];
    end
  end

  // First busy channel at or after the round-robin pointer.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_any && r_busy[(int'(r_rr) + k) % int'(NCH)]) begin
        w_any = 1'b1;
        w_gnt = IDX_W'((int'(r_rr) + k) % int'(NCH));
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= StIdle;
      r_rr    <= '0;
      r_grant <= '0;
      r_busy  <= '0;
      r_fin   <= '0;
      r_fill  <= '0;
      r_desc  <= '0;
      r_buf   <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_rptr[i]  <= '0;
        r_wptr[i]  <= '0;
        r_rem[i]   <= '0;
        r_fdata[i] <= '0;
      end
    end else begin
      r_fin <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (start[i] && !r_busy[i]) begin
          if (w_size[i] == '0) begin
            r_fin[i] <= 1'b1;
          end else begin
            r_busy[i]  <= 1'b1;
            r_fill[i]  <= fill[i];
            r_rem[i]   <= w_size[i];
            r_fdata[i] <= w_fdat[i];
            if (!fill[i] && (w_dst[i] > w_src[i])) begin
              r_desc[i] <= 1'b1;
              r_rptr[i] <= w_src[i] + ADDR_W'(w_size[i]) - ADDR_W'(1);
              r_wptr[i] <= w_dst[i] + ADDR_W'(w_size[i]) - ADDR_W'(1);
            end else begin
              r_desc[i] <= 1'b0;
              r_rptr[i] <= w_src[i];
              r_wptr[i] <= w_dst[i];
            end
          end
        end
      end

      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant <= w_gnt;
            if (r_fill[w_gnt]) begin
              r_state <= StWrite;
              r_wen   <= 1'b1;
              r_addr  <= r_wptr[w_gnt];
              r_wdata <= r_fdata[w_gnt];
            end else begin
              r_state <= StRead;
              r_ren   <= 1'b1;
              r_addr  <= r_rptr[w_gnt];
            end
          end
        end
        StRead: begin
          if (mem.mem_ready) begin
            r_buf   <= mem.mem_rdata;
            r_ren   <= 1'b0;
            r_state <= StWrite;
          end
        end
        StWrite: begin
          // A copy arrives here with the enable low and launches the write from the buffer.
          if (!r_wen) begin
            r_wen   <= 1'b1;
            r_addr  <= r_wptr[r_grant];
            r_wdata <= r_buf;
          end else if (mem.mem_ready) begin
            r_wen <= 1'b0;
            if (r_desc[r_grant]) begin
              r_rptr[r_grant] <= r_rptr[r_grant] - ADDR_W'(1);
              r_wptr[r_grant] <= r_wptr[r_grant] - ADDR_W'(1);
            end else begin
              r_rptr[r_grant] <= r_rptr[r_grant] + ADDR_W'(1);
              r_wptr[r_grant] <= r_wptr[r_grant] + ADDR_W'(1);
            end
            r_rem[r_grant] <= r_rem[r_grant] - LEN_W'(1);
            if (r_rem[r_grant] == LEN_W'(1)) begin
              r_busy[r_grant] <= 1'b0;
              r_fin[r_grant]  <= 1'b1;
            end
            r_rr    <= (r_grant == IDX_W'(NCH - 1)) ? '0 : r_grant + IDX_W'(1);
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy          = r_busy;
  assign finished      = r_fin;
  assign mem.mem_ren   = r_ren;
  assign mem.mem_wen   = r_wen;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
endmodule

// File: tb/tb_copier_mc.sv
// Randomised scoreboard bench for copier_mc: a memmove/fill reference model queues the
// expected writes per channel, and a negedge monitor retires them against the memory bus.
module tb_copier_mc;
  localparam int unsigned NCH    = 2;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 8;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [NCH-1:0]        start;
  logic [NCH-1:0]        fill;
  logic [NCH*ADDR_W-1:0] src_addr;
  logic [NCH*ADDR_W-1:0] dst_addr;
  logic [NCH*LEN_W-1:0]  copy_size;
  logic [NCH*DATA_W-1:0] fill_data;
  logic [NCH-1:0]        busy;
  logic [NCH-1:0]        finished;

  copier_mc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mbus ();

  copier_mc #(
    .NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .fill(fill), .src_addr(src_addr),
    .dst_addr(dst_addr), .copy_size(copy_size), .fill_data(fill_data), .busy(busy),
    .finished(finished), .mem(mbus.master)
  );

  always #5 CLK = ~CLK;

  // Memory model: mem_ready after wait_n extra cycles; whole-image preload on pl_go.
  logic [7:0] mem     [256];
  logic [7:0] img     [256];
  logic [7:0] ref_mem [256];
  logic       pl_go = 1'b0;
  int         wait_n = 0;
  int         wcnt = 0;

  assign mbus.mem_ready = (mbus.mem_ren || mbus.mem_wen) && (wcnt >= wait_n);
  assign mbus.mem_rdata = mem[mbus.mem_addr];

  always @(posedge CLK) begin
    if (pl_go) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mbus.mem_wen && mbus.mem_ready) begin
      mem[mbus.mem_addr] <= mbus.mem_wdata;
    end
    if ((mbus.mem_ren || mbus.mem_wen) && !mbus.mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct {
    int         ch;
    logic [7:0] a;
    logic [7:0] d;
  } wexp_t;

  wexp_t      exp_q[$];
  int         wlog[$];
  logic [7:0] walog[$];
  logic [7:0] rlog[$];
  int         fin_exp  [NCH];
  int         fin_cnt  [NCH];
  int         fin_time [NCH];
  int         n_checks = 0;
  int         n_errors = 0;
  int         req_cnt  = 0;
  int         wr_cnt   = 0;
  int         cyc      = 0;
  logic [NCH-1:0] busy_hist = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: memmove/fill semantics on a snapshot; write order follows the direction rule.
  task automatic model_start(input int ch, input bit f, input logic [7:0] s,
                             input logic [7:0] d, input logic [7:0] n, input logic [7:0] fd);
    logic [7:0] snap [256];
    wexp_t      item;
    bit         desc;
    int         k;
    fin_exp[ch]++;
    if (n != 0) begin
      snap = ref_mem;
      desc = !f && (d > s);
      for (int j = 0; j < int'(n); j++) begin
        k       = desc ? int'(n) - 1 - j : j;
        item.ch = ch;
        item.a  = 8'(int'(d) + k);
        item.d  = f ? fd : snap[8'(int'(s) + k)];
        exp_q.push_back(item);
        ref_mem[item.a] = item.d;
      end
    end
  endtask

  task automatic arm(input int ch, input bit f, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] n, input logic [7:0] fd);
    fill[ch]            = f;
    src_addr[ch*8 +: 8]  = s;
    dst_addr[ch*8 +: 8]  = d;
    copy_size[ch*8 +: 8] = n;
    fill_data[ch*8 +: 8] = fd;
    start[ch]           = 1'b1;
    model_start(ch, f, s, d, n, fd);
  endtask

  task automatic issue(input int ch, input bit f, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] n, input logic [7:0] fd);
    arm(ch, f, s, d, n, fd);
    @(negedge CLK);
    start = '0;
  endtask

  task automatic preload(input bit seq);
    for (int i = 0; i < 256; i++) begin
      img[i] = 8'($urandom);
      if (seq && i >= 'h10 && i < 'h18) img[i] = 8'(i - 'h10 + 1);
      ref_mem[i] = img[i];
    end
    pl_go = 1'b1;
    @(posedge CLK);
    #1 pl_go = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_fin(input int ch, input int maxc, output int t);
    t = 0;
    while (!finished[ch] && t < maxc) begin
      @(negedge CLK);
      t++;
    end
    chk($sformatf("fin_timeout_ch%0d", ch), t >= maxc, 0);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((busy != '0 || exp_q.size() != 0 || fin_exp[0] != 0 || fin_exp[1] != 0)
           && c < maxc) begin
      @(negedge CLK);
      #1;
      c++;
    end
    chk("drain_timeout", c >= maxc, 0);
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(name, bad, 0);
  endtask

  // Monitor: bus rules, write scoreboard, finished pulses.
  initial begin : monitor
    bit         pend;
    logic [17:0] prev_req;
    bit         matched;
    bit         seen;
    int         hit;
    int         npend;
    pend = 1'b0;
    prev_req = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      busy_hist = busy_hist | busy;
      if (!nRST) begin
        pend = 1'b0;
      end else begin
        if (pend) chk("req_stable", {mbus.mem_ren, mbus.mem_wen, mbus.mem_addr, mbus.mem_wdata},
                      prev_req);
        if (mbus.mem_ren || mbus.mem_wen) begin
          req_cnt++;
          chk("ren_wen_excl", mbus.mem_ren & mbus.mem_wen, 0);
        end
        pend     = (mbus.mem_ren || mbus.mem_wen) && !mbus.mem_ready;
        prev_req = {mbus.mem_ren, mbus.mem_wen, mbus.mem_addr, mbus.mem_wdata};
        if (mbus.mem_ren && mbus.mem_ready) rlog.push_back(mbus.mem_addr);
        if (mbus.mem_wen && mbus.mem_ready) begin
          wr_cnt++;
          matched = 1'b0;
          hit = 0;
          for (int c = 0; c < NCH; c++) begin
            seen = 1'b0;
            for (int j = 0; j < exp_q.size(); j++) begin
              if (!seen && !matched && exp_q[j].ch == c) begin
                seen = 1'b1;
                if (exp_q[j].a == mbus.mem_addr) begin
                  matched = 1'b1;
                  hit = j;
                end
              end
            end
          end
          if (matched) begin
            chk($sformatf("wdata@%02h", mbus.mem_addr), mbus.mem_wdata, exp_q[hit].d);
            wlog.push_back(exp_q[hit].ch);
            walog.push_back(mbus.mem_addr);
            exp_q.delete(hit);
          end else begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr 0x%02h data 0x%02h, required none",
                     mbus.mem_addr, mbus.mem_wdata);
          end
        end
        for (int i = 0; i < NCH; i++) begin
          if (finished[i]) begin
            chk($sformatf("fin_expected_ch%0d", i), fin_exp[i] > 0, 1);
            npend = 0;
            foreach (exp_q[j]) if (exp_q[j].ch == i) npend++;
            chk($sformatf("fin_after_writes_ch%0d", i), npend, 0);
            if (fin_exp[i] > 0) fin_exp[i]--;
            fin_cnt[i]++;
            fin_time[i] = cyc;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    int fc;
    int rc;
    int c;
    logic [7:0] s0, d0, n0, s1, d1, n1;
    bit f1;
    for (int i = 0; i < NCH; i++) begin
      fin_exp[i] = 0; fin_cnt[i] = 0; fin_time[i] = 0;
    end
    nRST = 1'b0; start = '0; fill = '0; src_addr = '0; dst_addr = '0;
    copy_size = '0; fill_data = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_ren", mbus.mem_ren, 0);
    chk("rst_wen", mbus.mem_wen, 0);
    chk("rst_addr", mbus.mem_addr, 0);
    chk("rst_wdata", mbus.mem_wdata, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // Single-channel copy with zero-wait memory: 4 cycles/word.
    preload(1'b0);
    busy_hist = '0;
    fc = fin_cnt[0];
    issue(0, 1'b0, 8'h00, 8'hF0, 8'd8, 8'h00);
    chk("t1_busy0", busy[0], 1);
    wait_fin(0, 200, t);
    chk("t1_copy_cycles", t, 32);
    wait_idle(100);
    repeat (3) @(negedge CLK);
    chk("t1_fin_once", fin_cnt[0] - fc, 1);
    chk("t1_busy1_quiet", busy_hist[1], 0);
    check_mem("t1_mem");

    // Concurrent copy on ch0 and fill on ch1 from the same edge.
    preload(1'b0);
    wlog.delete();
    arm(0, 1'b0, 8'h00, 8'h40, 8'd4, 8'h00);
    arm(1, 1'b1, 8'h00, 8'h80, 8'd6, 8'hA5);
    @(negedge CLK);
    start = '0;
    wait_idle(300);
    chk("t2_wlog_len", wlog.size(), 10);
    for (int k = 0; k < 7 && k + 1 < wlog.size(); k++)
      chk($sformatf("t2_alternate_%0d", k), wlog[k] != wlog[k+1], 1);
    chk("t2_fin_order", fin_time[0] < fin_time[1], 1);
    check_mem("t2_mem");

    // Overlapping memmove: descending, first write lands at 0x19.
    preload(1'b1);
    walog.delete();
    issue(1, 1'b0, 8'h10, 8'h12, 8'd8, 8'h00);
    wait_idle(300);
    chk("t3_first_waddr", (walog.size() > 0) ? int'(walog[0]) : -1, 'h19);
    for (int k = 0; k < 8; k++) chk($sformatf("t3_mem_%02h", 'h12 + k), mem['h12 + k], k + 1);
    check_mem("t3_mem");

    // Wrap-around source.
    preload(1'b0);
    rlog.delete();
    issue(0, 1'b0, 8'hFE, 8'h10, 8'd4, 8'h00);
    wait_idle(300);
    chk("t4_nreads", rlog.size(), 4);
    for (int k = 0; k < 4 && k < rlog.size(); k++)
      chk($sformatf("t4_raddr_%0d", k), rlog[k], (254 + k) % 256);
    check_mem("t4_mem");

    // Zero length: finished next cycle, no bus traffic.
    rc = req_cnt;
    fc = fin_cnt[1];
    issue(1, 1'b0, 8'h20, 8'h30, 8'd0, 8'h00);
    chk("t5_fin_now", finished[1], 1);
    chk("t5_not_busy", busy[1], 0);
    repeat (5) @(negedge CLK);
    chk("t5_no_requests", req_cnt - rc, 0);
    chk("t5_fin_once", fin_cnt[1] - fc, 1);

    // Fill at 2 cycles/word, then re-arm in the finished cycle.
    preload(1'b0);
    issue(1, 1'b1, 8'h00, 8'h30, 8'd4, 8'h5C);
    wait_fin(1, 100, t);
    chk("t6_fill_cycles", t, 8);
    issue(1, 1'b1, 8'h00, 8'h38, 8'd2, 8'hC3);
    chk("t6_rearm_busy", busy[1], 1);
    wait_fin(1, 100, t);
    chk("t6_rearm_cycles", t, 4);
    wait_idle(100);
    check_mem("t6_mem");

    // Slow memory: three wait cycles per access.
    wait_n = 3;
    preload(1'b0);
    arm(0, 1'b0, 8'h20, 8'h60, 8'd6, 8'h00);
    arm(1, 1'b0, 8'hA0, 8'hC8, 8'd5, 8'h00);
    @(negedge CLK);
    start = '0;
    wait_idle(1000);
    check_mem("t7_mem");

    // Reset mid-copy abandons the transfer.
    wait_n = 1;
    preload(1'b0);
    c = wr_cnt;
    issue(0, 1'b0, 8'h00, 8'h50, 8'd10, 8'h00);
    t = 0;
    while (wr_cnt < c + 2 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("t8_reach_writes", t >= 200, 0);
    fc = fin_cnt[0];
    #2 nRST = 1'b0;
    #1;
    chk("t8_rst_ren", mbus.mem_ren, 0);
    chk("t8_rst_wen", mbus.mem_wen, 0);
    chk("t8_rst_busy", busy, 0);
    exp_q.delete();
    fin_exp[0] = 0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (6) @(negedge CLK);
    chk("t8_no_fin", fin_cnt[0] - fc, 0);
    preload(1'b0);
    issue(0, 1'b0, 8'h00, 8'h50, 8'd10, 8'h00);
    wait_idle(500);
    check_mem("t8_restart_mem");

    // Randomised rounds on disjoint halves of memory, with an ignored start while busy.
    for (int r = 0; r < 24; r++) begin
      wait_n = $urandom_range(0, 2);
      preload(1'b0);
      s0 = 8'($urandom_range(0, 'h6F));
      d0 = 8'($urandom_range(0, 'h6F));
      n0 = 8'($urandom_range(1, 16));
      s1 = 8'($urandom_range('h80, 'hEF));
      d1 = 8'($urandom_range('h80, 'hEF));
      n1 = 8'($urandom_range(0, 16));
      f1 = 1'($urandom);
      issue(0, 1'b0, s0, d0, n0, 8'h00);
      fill[0] = 1'b1;
      dst_addr[7:0] = 8'h00;
      copy_size[7:0] = 8'd3;
      start[0] = 1'b1;
      @(negedge CLK);
      start = '0;
      repeat ($urandom_range(0, 4)) @(negedge CLK);
      issue(1, f1, s1, d1, n1, 8'($urandom));
      wait_idle(3000);
      check_mem($sformatf("rand_mem_%0d", r));
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/copier_mc.md
Name: copier_mc

Overview:
Parametrised multi-channel successor to the single-channel memory copier (DMA). It has NCH independent channels, and each channel is programmed with source, destination, length and mode. The block moves words through one shared memory port using beat-level round-robin arbitration. It sits between the control logic or bench and the single-port memory model. It adds two modes: fill (constant write) and memmove-safe overlapping copy.

Parameters:
NCH, 2, number of channels (1..8)
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
LEN_W, 8, transfer length width (words)

Ports:
CLK  in  1  clock; all logic on posedge
nRST  in  1  asynchronous active-low reset
start  in  NCH  per-channel start; sampled on posedge
fill  in  NCH  per-channel mode, latched at start: 0 = copy, 1 = fill
src_addr  in  NCH*ADDR_W  per-channel source base, latched at start
dst_addr  in  NCH*ADDR_W  per-channel destination base, latched at start
copy_size  in  NCH*LEN_W  per-channel word count, latched at start
fill_data  in  NCH*DATA_W  per-channel fill value, latched at start
busy  out  NCH  channel has an accepted, unfinished transfer
finished  out  NCH  one-cycle pulse per channel on completion
mem_ren  out  1  memory read request
mem_wen  out  1  memory write request
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1 during a read
mem_ready  in  1  memory completion; request retires on a posedge where it is 1

Behaviour:
- Reset (async, nRST=0): busy=0, finished=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0. All channel contexts are cleared and the arbiter pointer is set to channel 0. Reset mid-transfer abandons the transfer with no finished pulse.
- Start acceptance:
  - A start[i] sampled high while busy[i]=0 latches that channel's config and sets busy[i] on the same edge.
  - A start[i] while busy[i]=1 is ignored.
  - Simultaneous starts on several channels are all accepted.
- Zero length: start with copy_size=0 sets no busy. finished[i] pulses the cycle after the start edge, with no memory access.
- Direction (copy mode):
  - If dst > src (unsigned, at latch), the channel copies descending: from src+size-1/dst+size-1 down to src/dst. This makes overlapping moves safe.
  - Otherwise it copies ascending.
  - Fill mode is always ascending.
- Address arithmetic: modulo 2^ADDR_W; wrap-around past the top of memory is permitted and silent.
- Main FSM states: IDLE, READ, WRITE.
  - IDLE: if any busy channel exists, grant the first busy channel at or after the round-robin pointer.
    - Copy mode: go to READ with mem_ren=1, mem_addr = channel read pointer.
    - Fill mode: go straight to WRITE.
  - READ: hold mem_ren and mem_addr until mem_ready=1, then capture mem_rdata into the data buffer, drop mem_ren and go to WRITE.
  - WRITE:
    - mem_wen=1, mem_addr = channel write pointer, mem_wdata = buffer (copy) or fill_data (fill). Hold until mem_ready=1.
    - Then drop mem_wen, step that channel's pointers by ±1 and decrement its remaining count.
    - Advance the RR pointer to grant+1 (mod NCH) and return to IDLE.
- Request rules:
  - mem_ren and mem_wen are never high together.
  - Address, data and enable are stable while waiting for mem_ready.
  - Minimum one IDLE cycle between beats.
- Completion: when the remaining count reaches 0 on a write retire, busy[i] clears on that edge and finished[i] pulses for exactly the next cycle.
- Re-arm: a start[i] is accepted in the cycle finished[i] is high.
- Arbitration granularity is one word (one read+write pair). Channels interleave and no channel starves.
- Throughput with a zero-wait memory: copy is 4 cycles/word, fill is 2 cycles/word.

Test Plan:
- Single-channel copy: ch0 start src=0x00, dst=0xF0, size=8 over random data -> 0xF0..0xF7 equal 0x00..0x07. finished[0] pulses once. busy[1] stays 0.
- Two channels concurrent:
  - Stimulus: ch0 copies 0x00→0x40 with size 4; ch1 fills 0x80..0x85 with 0xA5, size 6, started the same edge.
  - Memory trace: writes alternate ch0/ch1 until ch0 is done.
  - Results: all data correct; finished[0] precedes finished[1].
- Overlap memmove: memory 0x10..0x17 = 1..8; copy src=0x10, dst=0x12, size=8 -> 0x12..0x19 = 1..8, with the first write at 0x19.
- Edge cases:
  - Wrap-around: src=0xFE, dst=0x10, size=4 reads 0xFE, 0xFF, 0x00, 0x01.
  - Zero length: size=0 gives finished after 1 cycle and no mem_ren/mem_wen.
- Handshake and reset:
  - Memory holds mem_ready low for 3 cycles per access -> requests stay stable and the copy is still correct.
  - nRST asserted mid-copy -> mem_ren/mem_wen drop immediately, busy=0, no finished pulse.
  - Restarting after reset completes normally.
